// File: rtl/wb_regfile.sv
// wb_regfile: architectural register file at the EXE/WB write-back boundary.
// - Two combinational read ports with a same-cycle write-back bypass.
// - A per-register 2-bit pending-writer scoreboard that drives the ID stall.
// - A sticky sb_err flag for scoreboard overflow and underflow.
// Optional build macro REG0_ZERO_EN: register 0 is hard-wired to zero. Its
// writes are dropped and it never becomes pending.
//
// Handshake: wen qualifies waddr/wdata and issue_en qualifies issue_addr. Both
// are single-cycle strobes with no ready back-pressure. ID is expected to hold
// issue_en low while stall is high; the file does not gate it.

`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef ASIZE
`define ASIZE 4
`endif

module wb_regfile #(
    parameter int DSIZE = `DSIZE,
    parameter int ASIZE = `ASIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr1,
    input  logic [ASIZE-1:0] raddr2,
    output logic [DSIZE-1:0] rdata1,
    output logic [DSIZE-1:0] rdata2,
    input  logic             issue_en,
    input  logic [ASIZE-1:0] issue_addr,
    output logic             stall,
    output logic             sb_err
);

    localparam int NREG = 1 << ASIZE;

    // Architectural state.
    logic [DSIZE-1:0] regs_q [NREG];

    // Pending-writer counters and the sticky error flag.
    logic [1:0]       cnt_q  [NREG];
    logic [1:0]       cnt_d  [NREG];
    logic             sb_err_q;
    logic             sb_err_d;

    // Effective write-back and issue strobes. With REG0_ZERO_EN, address 0
    // is masked off so it never touches the array or the scoreboard.
    logic             wr_ok;
    logic             iss_ok;

    // Bypass hits and per-port busy terms.
    logic             byp1;
    logic             byp2;
    logic             busy1;
    logic             busy2;

`ifdef REG0_ZERO_EN
    assign wr_ok  = wen      && (waddr      != '0);
    assign iss_ok = issue_en && (issue_addr != '0);
`else
    assign wr_ok  = wen;
    assign iss_ok = issue_en;
`endif

    assign byp1 = wr_ok && (waddr == raddr1);
    assign byp2 = wr_ok && (waddr == raddr2);

    // Read port 1: the value being written back this cycle wins over the array.
    always_comb begin
        rdata1 = byp1 ? wdata : regs_q[raddr1];
`ifdef REG0_ZERO_EN
        if (raddr1 == '0) begin
            rdata1 = '0;
        end
`endif
    end

    // Read port 2: same bypass rule as port 1.
    always_comb begin
        rdata2 = byp2 ? wdata : regs_q[raddr2];
`ifdef REG0_ZERO_EN
        if (raddr2 == '0) begin
            rdata2 = '0;
        end
`endif
    end

    // Busy per port. A lone outstanding writer that completes this cycle is
    // already covered by the bypass, so it does not stall.
    always_comb begin
        busy1 = (cnt_q[raddr1] > 2'd1) ||
                ((cnt_q[raddr1] == 2'd1) && !byp1);
        busy2 = (cnt_q[raddr2] > 2'd1) ||
                ((cnt_q[raddr2] == 2'd1) && !byp2);
    end

    // Stall looks only at current counters and write-back.
    // A same-cycle issue becomes visible one cycle later.
    assign stall  = busy1 || busy2;
    assign sb_err = sb_err_q;

    // Scoreboard next state.
    // - Issue and write-back to the same register cancel out.
    // - Saturating at 3 or 0 raises the sticky error instead of wrapping.
    always_comb begin : sb_next
        logic inc;
        logic dec;
        sb_err_d = sb_err_q;
        inc      = 1'b0;
        dec      = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            inc      = iss_ok && (issue_addr == ASIZE'(i));
            dec      = wr_ok  && (waddr      == ASIZE'(i));
            if (inc && !dec) begin
                if (cnt_q[i] == 2'd3) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 2'd1;
                end
            end else if (dec && !inc) begin
                if (cnt_q[i] == 2'd0) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - 2'd1;
                end
            end
        end
    end

    // Register array: write-back lands on the clock edge.
    // Reset clears every entry asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Scoreboard state.
    // Reset discards all pending counts and clears the sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= 2'd0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sb_err_q <= sb_err_d;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios followed by random traffic.
// Every output is compared against a reference model.
// The model tracks register values and pending-writer counts as plain arrays.

module tb_wb_regfile;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;

`ifdef REG0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic          issue_en;
  logic [AW-1:0] issue_addr;
  logic          stall;
  logic          sb_err;

  always #5 clk = ~clk;

  wb_regfile #(.DSIZE(DW), .ASIZE(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .stall      (stall),
    .sb_err     (sb_err)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] m_reg [NR];
  int            m_cnt [NR];
  logic          m_err;

  int vectors     = 0;
  int miscompares = 0;

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic bit is_real(input logic [AW-1:0] a);
    return !(R0Z && a == '0);
  endfunction

  // Value a reader sees: register 0 may be hard zero; otherwise the in-flight
  // write-back value if it targets this address, else the stored value.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
    if (!is_real(ra)) return '0;
    if (wen && waddr == ra) return wdata;
    return m_reg[ra];
  endfunction

  // A port is busy if any writer for its register is still outstanding once
  // this cycle's write-back (if any) is counted as done.
  function automatic bit exp_busy(input logic [AW-1:0] ra);
    int left;
    if (!is_real(ra)) return 1'b0;
    left = m_cnt[ra] - ((wen && waddr == ra) ? 1 : 0);
    return left > 0;
  endfunction

  function automatic void model_edge();
    int delta [NR];
    for (int i = 0; i < NR; i++) delta[i] = 0;
    if (wen && is_real(waddr)) begin
      m_reg[waddr]  = wdata;
      delta[waddr] -= 1;
    end
    if (issue_en && is_real(issue_addr)) delta[issue_addr] += 1;
    for (int i = 0; i < NR; i++) begin
      if (delta[i] > 0) begin
        if (m_cnt[i] == 3) m_err = 1'b1;
        else m_cnt[i] += 1;
      end else if (delta[i] < 0) begin
        if (m_cnt[i] == 0) m_err = 1'b1;
        else m_cnt[i] -= 1;
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rdata1"}, rdata1, exp_rd(raddr1));
    chk({tag, ".rdata2"}, rdata2, exp_rd(raddr2));
    chk({tag, ".stall"}, {15'b0, stall}, {15'b0, (exp_busy(raddr1) || exp_busy(raddr2))});
    chk({tag, ".sb_err"}, {15'b0, sb_err}, {15'b0, m_err});
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle of inputs, check at the falling edge, then advance the
  // model on the rising edge. Returns 1 time unit after that edge.
  task automatic step(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                      input logic ie, input logic [AW-1:0] ia, input string tag);
    wen = w; waddr = wa; wdata = wd;
    raddr1 = r1; raddr2 = r2;
    issue_en = ie; issue_addr = ia;
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    wen = 1'b0; waddr = '0; wdata = '0;
    issue_en = 1'b0; issue_addr = '0;
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    rst = 1'b1;
    m_reset();
    #1;
    check_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic          w;
    logic          ie;
    logic [AW-1:0] wa;
    logic [AW-1:0] ia;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;

    idle_inputs();
    raddr1 = 4'd3; raddr2 = 4'd9;
    rst = 1'b1;
    m_reset();
    @(negedge clk);
    check_outputs("reset_state");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Write then read r5: bypass in the same cycle, then from the array.
    step(0, 0, 0,       0, 5, 1, 5, "wr5_issue");
    step(1, 5, 16'hA5A5, 0, 5, 0, 0, "wr5_bypass");
    step(0, 0, 0,       0, 5, 0, 0, "wr5_array");

    // Single writer hazard on r7.
    step(0, 0, 0,       7, 0, 1, 7, "haz7_c0");
    step(0, 0, 0,       7, 0, 0, 0, "haz7_c1");
    step(1, 7, 16'h1234, 7, 0, 0, 0, "haz7_c2");
    step(0, 0, 0,       7, 0, 0, 0, "haz7_c3");

    // Two writers in flight on r2.
    step(0, 0, 0,       2, 0, 1, 2, "two2_c0");
    step(0, 0, 0,       2, 0, 1, 2, "two2_c1");
    step(1, 2, 16'h1111, 2, 0, 0, 0, "two2_c2");
    step(1, 2, 16'h2222, 2, 0, 0, 0, "two2_c3");
    step(0, 0, 0,       2, 2, 0, 0, "two2_c4");

    // Issue and write-back on the same register in one cycle cancel out.
    step(0, 0, 0,       6, 0, 1, 6, "net6_c0");
    step(1, 6, 16'h0606, 6, 0, 1, 6, "net6_c1");
    step(0, 0, 0,       6, 0, 0, 0, "net6_c2");

    // Register 0: ordinary, or hard zero under REG0_ZERO_EN.
    step(0, 0, 0,       0, 0, 1, 0, "r0_issue");
    step(1, 0, 16'hFFFF, 0, 0, 0, 0, "r0_write");
    step(0, 0, 0,       0, 0, 1, 0, "r0_issue2");
    step(0, 0, 0,       0, 0, 0, 0, "r0_read");
    step(1, 0, 16'hFFFF, 0, 0, 0, 0, "r0_drain");

    // Asynchronous reset mid-cycle while r3 holds 0x55 and has a writer pending.
    step(0, 0, 0,       3, 0, 1, 3, "rst3_issue");
    step(1, 3, 16'h0055, 3, 0, 1, 3, "rst3_wr");
    idle_inputs();
    raddr1 = 4'd3; raddr2 = 4'd0;
    @(negedge clk);
    check_outputs("rst3_pre");
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    check_outputs("rst3_async");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Overflow: four issues to r4, then drain three writers.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4, 0, 1, 4, "ovf4_issue");
    step(0, 0, 0,       4, 0, 0, 0, "ovf4_err");
    step(1, 4, 16'h0001, 4, 0, 0, 0, "ovf4_wb1");
    step(1, 4, 16'h0002, 4, 0, 0, 0, "ovf4_wb2");
    step(1, 4, 16'h0003, 4, 0, 0, 0, "ovf4_wb3");
    step(0, 0, 0,       4, 4, 0, 0, "ovf4_done");
    do_reset("ovf4_reset");

    // Underflow: write-back to r9 with nothing pending, sticky until reset.
    step(1, 9, 16'h0999, 9, 0, 0, 0, "unf9_wb");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 9, 1, 0, 0, "unf9_hold");
    do_reset("unf9_reset");
    step(0, 0, 0,       9, 0, 0, 0, "unf9_clear");

    // Unconstrained random traffic, including illegal over/underflow.
    for (int n = 0; n < 150; n++) begin
      w  = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, NR - 1));
      ia = 4'($urandom_range(0, NR - 1));
      r1 = ($urandom_range(0, 1) == 1) ? wa : 4'($urandom_range(0, NR - 1));
      r2 = 4'($urandom_range(0, NR - 1));
      step(w, wa, 16'($urandom), r1, r2, ie, ia, "rand_any");
    end
    do_reset("rand_reset");

    // Pipeline-legal random traffic: write-back only to pending registers,
    // issue only below saturation.
    for (int n = 0; n < 300; n++) begin
      wa = 4'($urandom_range(0, NR - 1));
      ia = 4'($urandom_range(0, NR - 1));
      w  = ($urandom_range(0, 2) != 0) && (m_cnt[wa] > 0);
      ie = ($urandom_range(0, 2) == 0) && (m_cnt[ia] < 3);
      r1 = ($urandom_range(0, 1) == 1) ? wa : 4'($urandom_range(0, NR - 1));
      r2 = ($urandom_range(0, 1) == 1) ? ia : 4'($urandom_range(0, NR - 1));
      step(w, wa, 16'($urandom), r1, r2, ie, ia, "rand_legal");
    end

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
